// File: rtl/int_service.sv
// CPU-side interrupt responder: IE/IP SFRs, two-level in-service tracking,
// priority arbitration and a vectored request/acknowledge handshake to the core.
module int_service #(
    parameter logic [7:0]  IE_ADDR  = 8'hA8,
    parameter logic [7:0]  IP_ADDR  = 8'hB8,
    parameter logic [15:0] VEC_BASE = 16'h0003,
    parameter logic [15:0] VEC_STEP = 16'h0008
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  int_pend,
    output logic [4:0]  int_clr,
    input  logic        sfr_we,
    input  logic [7:0]  sfr_addr,
    input  logic [7:0]  sfr_wdata,
    output logic [7:0]  sfr_rdata,
    output logic        int_req,
    output logic [15:0] int_vec,
    input  logic        int_ack,
    input  logic        reti,
    input  logic        hold,
    output logic [1:0]  isr_level
);

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    state_e      state_q, state_d;
    logic        ea_q, ea_d;
    logic [4:0]  ie_q, ie_d;
    logic [4:0]  ip_q, ip_d;
    logic [1:0]  isr_q, isr_d;
    logic [1:0]  isr_after_reti;
    logic [15:0] vec_q, vec_d;
    logic [2:0]  win_q, win_d;
    logic        lvl_q, lvl_d;
    logic [4:0]  clr_q, clr_d;

    logic [4:0]  elig;
    logic [4:0]  elig_hi;
    logic [4:0]  elig_lo;
    logic [4:0]  grp;
    logic        any_elig;
    logic        win_lvl;
    logic [2:0]  win_idx;
    logic [15:0] win_vec;

    // A low-priority source needs both levels idle; a high one only needs the high level idle.
    always_comb begin
        elig = '0;
        for (int i = 0; i < 5; i++) begin
            elig[i] = ea_q & ie_q[i] & int_pend[i] &
                      (ip_q[i] ? ~isr_q[1] : ~(isr_q[1] | isr_q[0]));
        end
    end

    assign elig_hi  = elig & ip_q;
    assign elig_lo  = elig & ~ip_q;
    assign any_elig = |elig;
    assign win_lvl  = |elig_hi;
    assign grp      = win_lvl ? elig_hi : elig_lo;

    // Scan downwards so the lowest set index is the one that sticks.
    always_comb begin
        win_idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (grp[i]) begin
                win_idx = 3'(i);
            end
        end
    end

    assign win_vec = VEC_BASE + VEC_STEP * 16'(win_idx);

    // SFR writes land at the edge; arbitration this cycle sees the old values.
    always_comb begin
        ea_d = ea_q;
        ie_d = ie_q;
        ip_d = ip_q;
        if (sfr_we) begin
            if (sfr_addr == IE_ADDR) begin
                ea_d = sfr_wdata[7];
                ie_d = sfr_wdata[4:0];
            end else if (sfr_addr == IP_ADDR) begin
                ip_d = sfr_wdata[4:0];
            end
        end
    end

    always_comb begin
        sfr_rdata = 8'h00;
        if (sfr_addr == IE_ADDR) begin
            sfr_rdata = {ea_q, 2'b00, ie_q};
        end else if (sfr_addr == IP_ADDR) begin
            sfr_rdata = {3'b000, ip_q};
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        win_d   = win_q;
        lvl_d   = lvl_q;
        clr_d   = '0;

        // RETI releases the innermost level before any acknowledge sets a new one.
        isr_after_reti = isr_q;
        if (reti) begin
            if (isr_q[1]) begin
                isr_after_reti[1] = 1'b0;
            end else if (isr_q[0]) begin
                isr_after_reti[0] = 1'b0;
            end
        end
        isr_d = isr_after_reti;

        case (state_q)
            StIdle: begin
                if (any_elig && !hold) begin
                    state_d = StReq;
                    vec_d   = win_vec;
                    win_d   = win_idx;
                    lvl_d   = win_lvl;
                end
            end
            StReq: begin
                if (int_ack) begin
                    // The core has called the presented vector, so service the latched winner.
                    state_d = StIdle;
                    vec_d   = '0;
                    clr_d   = 5'b00001 << win_q;
                    if (lvl_q) begin
                        isr_d[1] = 1'b1;
                    end else begin
                        isr_d[0] = 1'b1;
                    end
                end else if (!any_elig) begin
                    state_d = StIdle;
                    vec_d   = '0;
                end else begin
                    vec_d = win_vec;
                    win_d = win_idx;
                    lvl_d = win_lvl;
                end
            end
            default: begin
                state_d = StIdle;
                vec_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ea_q    <= 1'b0;
            ie_q    <= '0;
            ip_q    <= '0;
            isr_q   <= '0;
            vec_q   <= '0;
            win_q   <= '0;
            lvl_q   <= 1'b0;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            ea_q    <= ea_d;
            ie_q    <= ie_d;
            ip_q    <= ip_d;
            isr_q   <= isr_d;
            vec_q   <= vec_d;
            win_q   <= win_d;
            lvl_q   <= lvl_d;
            clr_q   <= clr_d;
        end
    end

    assign int_req   = (state_q == StReq);
    assign int_vec   = vec_q;
    assign int_clr   = clr_q;
    assign isr_level = isr_q;

endmodule

// File: tb/tb_int_service.sv
// Directed bench for int_service; request vectors and clear pulses are checked
// by a negedge monitor against queues filled by the stimulus.
module tb_int_service;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  int_pend;
    logic [4:0]  int_clr;
    logic        sfr_we;
    logic [7:0]  sfr_addr;
    logic [7:0]  sfr_wdata;
    logic [7:0]  sfr_rdata;
    logic        int_req;
    logic [15:0] int_vec;
    logic        int_ack;
    logic        reti;
    logic        hold;
    logic [1:0]  isr_level;

    int errors = 0;
    int checks = 0;
    logic        mon_en = 1'b0;
    logic        prev_req = 1'b0;
    logic [15:0] prev_vec = '0;
    logic [15:0] exp_vec_q[$];
    logic [4:0]  exp_clr_q[$];

    int_service dut (
        .clk       (clk),
        .rst       (rst),
        .int_pend  (int_pend),
        .int_clr   (int_clr),
        .sfr_we    (sfr_we),
        .sfr_addr  (sfr_addr),
        .sfr_wdata (sfr_wdata),
        .sfr_rdata (sfr_rdata),
        .int_req   (int_req),
        .int_vec   (int_vec),
        .int_ack   (int_ack),
        .reti      (reti),
        .hold      (hold),
        .isr_level (isr_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sfr_wr(input logic [7:0] addr, input logic [7:0] data);
        sfr_we    = 1'b1;
        sfr_addr  = addr;
        sfr_wdata = data;
        tick();
        sfr_we = 1'b0;
    endtask

    task automatic sfr_rd(input string name, input logic [7:0] addr, input logic [7:0] exp);
        sfr_addr = addr;
        #1;
        check(name, 16'(sfr_rdata), 16'(exp));
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (int_req !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        check(name, 16'(int_req), 16'h1);
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic pulse_reti();
        reti = 1'b1;
        tick();
        reti = 1'b0;
    endtask

    // Monitor: every new request vector and every clear pulse must be expected.
    always @(negedge clk) begin
        if (mon_en) begin
            if (int_req === 1'b1 && (prev_req !== 1'b1 || int_vec !== prev_vec)) begin
                if (exp_vec_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got vec %h expected no request", int_vec);
                end else begin
                    check("req_vec", int_vec, exp_vec_q.pop_front());
                end
            end
            if (int_clr !== 5'b0) begin
                if (exp_clr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_clr: got %b expected 00000", int_clr);
                end else begin
                    check("int_clr", 16'(int_clr), 16'(exp_clr_q.pop_front()));
                end
            end
            prev_req = int_req;
            prev_vec = int_vec;
        end
    end

    initial begin
        rst       = 1'b1;
        int_pend  = '0;
        sfr_we    = 1'b0;
        sfr_addr  = 8'h00;
        sfr_wdata = 8'h00;
        int_ack   = 1'b0;
        reti      = 1'b0;
        hold      = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        mon_en = 1'b1;

        // Reset state and SFR readback
        check("rst_req", 16'(int_req), 16'h0);
        check("rst_vec", int_vec, 16'h0000);
        check("rst_isr", 16'(isr_level), 16'h0);
        sfr_rd("rst_ie", 8'hA8, 8'h00);
        sfr_rd("rst_ip", 8'hB8, 8'h00);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check("idle_ack_isr", 16'(isr_level), 16'h0);
        sfr_wr(8'hA8, 8'hE1);
        sfr_rd("ie_mask", 8'hA8, 8'h81);
        sfr_wr(8'hB8, 8'hFF);
        sfr_rd("ip_mask", 8'hB8, 8'h1F);
        sfr_rd("other_addr", 8'h80, 8'h00);
        sfr_wr(8'hB8, 8'h00);
        sfr_wr(8'hA8, 8'h81);

        // Single int0 request: one-cycle latency, ack, clear, level
        exp_vec_q.push_back(16'h0003);
        int_pend = 5'b00001;
        #1;
        check("latency_zero", 16'(int_req), 16'h0);
        tick();
        check("latency_one", 16'(int_req), 16'h1);
        exp_clr_q.push_back(5'b00001);
        pulse_ack();
        int_pend = 5'b00000;
        check("ack_drop_req", 16'(int_req), 16'h0);
        check("ack_isr_lo", 16'(isr_level), 16'h1);
        tick();
        pulse_reti();
        check("reti_lo", 16'(isr_level), 16'h0);

        // int1 beats uart; uart waits for reti
        sfr_wr(8'hA8, 8'h9F);
        exp_vec_q.push_back(16'h0013);
        int_pend = 5'b10100;
        wait_req("req_int1");
        exp_clr_q.push_back(5'b00100);
        pulse_ack();
        int_pend = 5'b10000;
        tick();
        check("uart_blocked", 16'(int_req), 16'h0);
        tick();
        exp_vec_q.push_back(16'h0023);
        pulse_reti();
        check("reti_int1", 16'(isr_level), 16'h0);
        wait_req("req_uart");
        exp_clr_q.push_back(5'b10000);
        pulse_ack();
        int_pend = 5'b00000;
        check("uart_isr_lo", 16'(isr_level), 16'h1);

        // High uart nests over the active low ISR
        sfr_wr(8'hB8, 8'h10);
        exp_vec_q.push_back(16'h0023);
        int_pend = 5'b10000;
        wait_req("req_nest");
        exp_clr_q.push_back(5'b10000);
        pulse_ack();
        int_pend = 5'b00000;
        check("nest_isr", 16'(isr_level), 16'h3);
        pulse_reti();
        check("reti_hi_first", 16'(isr_level), 16'h1);
        pulse_reti();
        check("reti_lo_second", 16'(isr_level), 16'h0);
        pulse_reti();
        check("reti_empty", 16'(isr_level), 16'h0);

        // High ISR active blocks everything until reti
        exp_vec_q.push_back(16'h0023);
        int_pend = 5'b10000;
        wait_req("req_hi");
        exp_clr_q.push_back(5'b10000);
        pulse_ack();
        int_pend = 5'b00000;
        check("hi_isr", 16'(isr_level), 16'h2);
        sfr_wr(8'hB8, 8'h02);
        int_pend = 5'b00011;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hi_blocks", 16'(int_req), 16'h0);
        end
        exp_vec_q.push_back(16'h000B);
        pulse_reti();
        wait_req("req_t0_hi");
        exp_clr_q.push_back(5'b00010);
        pulse_ack();
        int_pend = 5'b00001;
        tick();
        check("lo_blocked_by_hi", 16'(int_req), 16'h0);
        exp_vec_q.push_back(16'h0003);
        pulse_reti();
        wait_req("req_int0_lo");
        exp_clr_q.push_back(5'b00001);
        pulse_ack();
        int_pend = 5'b00000;
        check("int0_isr", 16'(isr_level), 16'h1);

        // reti and ack together: clear low first, then set high
        exp_vec_q.push_back(16'h000B);
        int_pend = 5'b00010;
        wait_req("req_t0_again");
        exp_clr_q.push_back(5'b00010);
        int_ack = 1'b1;
        reti    = 1'b1;
        tick();
        int_ack  = 1'b0;
        reti     = 1'b0;
        int_pend = 5'b00000;
        check("reti_ack_same", 16'(isr_level), 16'h2);
        pulse_reti();
        check("reti_after_same", 16'(isr_level), 16'h0);

        // Pre-emption inside REQ, then withdrawal by IE write
        sfr_wr(8'hB8, 8'h00);
        exp_vec_q.push_back(16'h001B);
        int_pend = 5'b01000;
        wait_req("req_t1");
        exp_vec_q.push_back(16'h0003);
        int_pend = 5'b01001;
        tick();
        check("replace_vec", int_vec, 16'h0003);
        sfr_wr(8'hA8, 8'h00);
        check("write_edge_req", 16'(int_req), 16'h1);
        tick();
        check("withdraw_req", 16'(int_req), 16'h0);
        check("withdraw_vec", int_vec, 16'h0000);
        int_pend = 5'b00000;

        // hold gating in IDLE, no effect in REQ
        sfr_wr(8'hA8, 8'h83);
        sfr_wr(8'hB8, 8'h02);
        hold = 1'b1;
        int_pend = 5'b00001;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_blocks", 16'(int_req), 16'h0);
        end
        exp_vec_q.push_back(16'h0003);
        hold = 1'b0;
        wait_req("req_after_hold");
        hold = 1'b1;
        tick();
        check("hold_in_req", 16'(int_req), 16'h1);
        exp_clr_q.push_back(5'b00001);
        pulse_ack();
        int_pend = 5'b00010;
        hold = 1'b0;
        check("hold_ack_isr", 16'(isr_level), 16'h1);
        exp_vec_q.push_back(16'h000B);
        wait_req("req_before_rst");
        sfr_rd("ie_before_rst", 8'hA8, 8'h83);

        // Reset while requesting
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_req", 16'(int_req), 16'h0);
        check("mid_rst_vec", int_vec, 16'h0000);
        check("mid_rst_isr", 16'(isr_level), 16'h0);
        sfr_rd("mid_rst_ie", 8'hA8, 8'h00);
        sfr_rd("mid_rst_ip", 8'hB8, 8'h00);
        tick();
        check("post_rst_req", 16'(int_req), 16'h0);
        int_pend = 5'b00000;
        tick();
        tick();

        check("vec_queue_empty", 16'(exp_vec_q.size()), 16'h0);
        check("clr_queue_empty", 16'(exp_clr_q.size()), 16'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
